// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the memory port arbiter
// and its byte-merge helper.
package mem_arb_pkg;

  // Arbiter FSM: either free to grant, or finishing the write half of a
  // read-modify-write.
  typedef enum logic {
    IDLE   = 1'b0,
    RMW_WR = 1'b1
  } arb_state_t;

  // Requester IDs, used to remember who was granted most recently.
  localparam logic GNT_IF = 1'b0;
  localparam logic GNT_LS = 1'b1;

  // Byte-enable patterns that avoid the read-modify-write path.
  localparam logic [3:0] BE_FULL = 4'b1111;
  localparam logic [3:0] BE_NONE = 4'b0000;

endpackage

// File: rtl/mem_byte_merge.sv
// mem_byte_merge: combinational lane merge. Byte lane k of the result
// comes from new_word when be[k] is set, otherwise from old_word.
// Shared between the store read-modify-write and the cache fill path.
module mem_byte_merge (
  input  logic [31:0] old_word,
  input  logic [31:0] new_word,
  input  logic [3:0]  be,
  output logic [31:0] merged
);

  logic [31:0] lane_mask;

  // Widen each byte enable into a full byte of mask and blend the words.
  always_comb begin
    lane_mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    merged    = (new_word & lane_mask) | (old_word & ~lane_mask);
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port, word-wide RAM between the
// instruction fetch (IF) and load/store (LS) requesters with round-robin
// arbitration. Reads return one cycle after the grant; byte and halfword
// stores become a two-cycle read-modify-write.
// Build option: define MEM_ARB_PERF_CNT_EN to add saturating stall
// counters perf_if_stall / perf_ls_stall.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_DEPTH = 16
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 if_req,
  input  logic [MEM_DEPTH-1:0] if_addr,
  output logic                 if_gnt,
  output logic                 if_rvalid,
  output logic [31:0]          if_rdata,
  input  logic                 ls_req,
  input  logic                 ls_we,
  input  logic [3:0]           ls_be,
  input  logic [MEM_DEPTH-1:0] ls_addr,
  input  logic [31:0]          ls_wdata,
  output logic                 ls_gnt,
  output logic                 ls_rvalid,
  output logic [31:0]          ls_rdata,
  output logic                 ram_we,
  output logic [MEM_DEPTH-1:0] ram_addr,
  output logic [31:0]          ram_d,
  input  logic [31:0]          ram_q
`ifdef MEM_ARB_PERF_CNT_EN
  ,
  output logic [31:0]          perf_if_stall,
  output logic [31:0]          perf_ls_stall
`endif
);

  arb_state_t           state;
  logic                 last_gnt;
  logic                 sel_if;
  logic                 sel_ls;
  logic                 ls_read;
  logic                 rmw_start;
  logic [MEM_DEPTH-3:0] rmw_word;
  logic [3:0]           rmw_be;
  logic [31:0]          rmw_wdata;
  logic [31:0]          rmw_old;
  logic [31:0]          merged_word;
  logic [MEM_DEPTH-1:0] if_word_addr;
  logic [MEM_DEPTH-1:0] ls_word_addr;
  logic                 unused_addr_bits;

  // The RAM is word-wide, so the byte offset never reaches it.
  assign if_word_addr     = {if_addr[MEM_DEPTH-1:2], 2'b00};
  assign ls_word_addr     = {ls_addr[MEM_DEPTH-1:2], 2'b00};
  assign unused_addr_bits = ^{if_addr[1:0], ls_addr[1:0]};

  mem_byte_merge u_merge (
    .old_word (rmw_old),
    .new_word (rmw_wdata),
    .be       (rmw_be),
    .merged   (merged_word)
  );

  // Round-robin pick: on a conflict the port that did not win last time goes.
  always_comb begin
    sel_if = 1'b0;
    sel_ls = 1'b0;
    if (reset_n && state == IDLE) begin
      if (if_req && ls_req) begin
        sel_if = (last_gnt == GNT_LS);
        sel_ls = (last_gnt == GNT_IF);
      end else begin
        sel_if = if_req;
        sel_ls = ls_req;
      end
    end
  end

  // Drive the RAM and the grants for whichever access owns this cycle.
  always_comb begin
    if_gnt    = 1'b0;
    ls_gnt    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_d     = '0;
    ls_read   = 1'b0;
    rmw_start = 1'b0;
    if (state == RMW_WR) begin
      ram_we   = 1'b1;
      ram_addr = {rmw_word, 2'b00};
      ram_d    = merged_word;
      ls_gnt   = 1'b1;
    end else if (sel_if) begin
      if_gnt   = 1'b1;
      ram_addr = if_word_addr;
    end else if (sel_ls) begin
      if (!ls_we) begin
        ls_gnt   = 1'b1;
        ls_read  = 1'b1;
        ram_addr = ls_word_addr;
      end else if (ls_be == BE_FULL) begin
        ls_gnt   = 1'b1;
        ram_we   = 1'b1;
        ram_addr = ls_word_addr;
        ram_d    = ls_wdata;
      end else if (ls_be == BE_NONE) begin
        ls_gnt   = 1'b1;
      end else begin
        rmw_start = 1'b1;
        ram_addr  = ls_word_addr;
      end
    end
  end

  // FSM, round-robin history and the latched partial-store operands.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      last_gnt  <= GNT_LS;
      rmw_word  <= '0;
      rmw_be    <= '0;
      rmw_wdata <= '0;
      rmw_old   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (sel_if) begin
            last_gnt <= GNT_IF;
          end else if (sel_ls) begin
            last_gnt <= GNT_LS;
          end
          if (rmw_start) begin
            state     <= RMW_WR;
            rmw_word  <= ls_addr[MEM_DEPTH-1:2];
            rmw_be    <= ls_be;
            rmw_wdata <= ls_wdata;
            rmw_old   <= ram_q;
          end
        end
        RMW_WR: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Read return path: capture RAM data on a read grant, flag it next cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      if_rvalid <= 1'b0;
      if_rdata  <= '0;
      ls_rvalid <= 1'b0;
      ls_rdata  <= '0;
    end else begin
      if_rvalid <= if_gnt;
      ls_rvalid <= ls_read;
      if (if_gnt) begin
        if_rdata <= ram_q;
      end
      if (ls_read) begin
        ls_rdata <= ram_q;
      end
    end
  end

`ifdef MEM_ARB_PERF_CNT_EN
  // Saturating count of cycles each port spent requesting without a grant.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      perf_if_stall <= '0;
      perf_ls_stall <= '0;
    end else begin
      if (if_req && !if_gnt && perf_if_stall != 32'hFFFF_FFFF) begin
        perf_if_stall <= perf_if_stall + 32'd1;
      end
      if (ls_req && !ls_gnt && perf_ls_stall != 32'hFFFF_FFFF) begin
        perf_ls_stall <= perf_ls_stall + 32'd1;
      end
    end
  end
`endif

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port byte-addressable RAM between two requesters: instruction fetch (IF) and load/store unit (LS).
- Grants one request per cycle using round-robin arbitration.
- Registers read data and returns it one cycle after the grant.
- The RAM only writes whole words, so byte and halfword stores are done as a two-cycle read-modify-write (RMW).

Parameters:
- MEM_DEPTH, 16, byte-address width; must match the RAM instance.

Ports:
- clock  in  1  system clock; all state updates on posedge
- reset_n  in  1  asynchronous, active-low reset
- if_req  in  1  IF read request; held stable until if_gnt
- if_addr  in  MEM_DEPTH  IF byte address; bits [1:0] ignored
- if_gnt  out  1  IF request accepted this cycle
- if_rvalid  out  1  IF read data valid (1-cycle pulse)
- if_rdata  out  32  IF read data
- ls_req  in  1  LS request; held stable until ls_gnt
- ls_we  in  1  1 = store, 0 = load
- ls_be  in  4  store byte enables; ls_be[k] selects byte lane k, i.e. bits 8k+7:8k
- ls_addr  in  MEM_DEPTH  LS byte address; bits [1:0] ignored
- ls_wdata  in  32  store data, lane-aligned
- ls_gnt  out  1  LS request accepted/completed this cycle
- ls_rvalid  out  1  LS load data valid (1-cycle pulse)
- ls_rdata  out  32  LS load data
- ram_we  out  1  RAM write enable
- ram_addr  out  MEM_DEPTH  RAM address, always {addr[MEM_DEPTH-1:2],2'b00}
- ram_d  out  32  RAM write data
- ram_q  in  32  RAM combinational read data; reads 0 while ram_we=1

Behaviour:
- Reset values: every output 0; state=IDLE; last_gnt=LS, so IF wins the first conflict.
- States: IDLE, RMW_WR.
- IDLE, single requester: that requester is granted.
- IDLE, both requesting: grant the port not equal to last_gnt. last_gnt updates on every grant. An RMW counts as an LS grant.
- Read grant (IF read, or LS with ls_we=0):
  - Drive ram_addr and assert gnt in the same cycle.
  - Capture ram_q into the port's rdata register.
  - Assert that port's rvalid on the next cycle only.
  - Back-to-back reads may be granted every cycle, giving full throughput.
- rdata holds its value until the next read completes for that port.
- Full store (ls_be=4'b1111): ram_we=1, ram_d=ls_wdata, ls_gnt=1 in the same cycle; no rvalid.
- Empty store (ls_be=4'b0000): ls_gnt=1 immediately; ram_we stays 0; no RAM access.
- Partial store (any other ls_be):
  - Cycle 1 (IDLE): ram_we=0, read the word, latch ram_q, ls_addr, ls_be and ls_wdata; go to RMW_WR; ls_gnt=0.
  - Cycle 2 (RMW_WR): ram_we=1; ram_d = merged word (lane k from latched wdata if be[k], else from latched old word); ls_gnt=1; return to IDLE.
  - IF is not granted in either cycle.
- if_gnt and ls_gnt are never high in the same cycle. ram_we is only ever high for a granted LS store.
- A read to a word being written in the same cycle cannot occur (single port). A read granted the cycle after a store returns the new value.
- Reset asserted mid-RMW: abort to IDLE; no write is issued; the word is unchanged; pending rvalid is cleared.

Optional Feature:
- Macro: MEM_ARB_PERF_CNT_EN.
- With it defined: two added outputs, perf_if_stall[31:0] and perf_ls_stall[31:0]. Each counts cycles where its req=1 and gnt=0, saturates at 32'hFFFF_FFFF, and resets to 0.
- Without it: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package mem_arb_pkg:
  - state encoding (IDLE, RMW_WR)
  - requester ID constants (GNT_IF=0, GNT_LS=1)
  - BE_FULL=4'b1111, BE_NONE=4'b0000
- One sub-module, mem_byte_merge: purely combinational (old word, new word, be) -> merged word. It is reused by a later cache fill path.

Test Plan:
- Back-to-back IF reads: preload 0x0=32'hDEAD_BEEF and 0x4=32'h0000_0013; IF reads 0x0 then 0x4 on consecutive cycles -> if_gnt both cycles; if_rvalid on cycles 2 and 3 with those values.
- Conflict: IF and LS both hold read requests for 6 cycles -> grants go IF,LS,IF,LS,IF,LS; never both high.
- Partial store: 0x10=32'h1122_3344; LS store be=4'b0010, wdata=32'h0000_AB00 -> cycle 1 ram_we=0, ls_gnt=0; cycle 2 ram_we=1, ram_d=32'h1122_AB44, ls_gnt=1; a concurrent if_req is stalled both cycles and granted in cycle 3.
- Full store then load: store 32'hCAFE_F00D to 0x20, then load 0x20 -> ls_rvalid with 32'hCAFE_F00D; misaligned load at 0x22 returns the same word.
- Reset mid-RMW: start a be=4'b0001 store to 0x30 (holds 32'h0); pull reset_n low in cycle 1 -> no ram_we pulse; 0x30 still 32'h0; all outputs 0.
- With MEM_ARB_PERF_CNT_EN: 4-cycle conflict followed by a 2-cycle RMW with IF pending -> perf_if_stall and perf_ls_stall match the stall cycles counted by the bench model.
